// File: rtl/blood_tracker_pkg.sv
// Shared types and constants for the fighter health tracker.
// Holds the HP width, the round state encoding, the winner codes and the damage field positions.
package kof_pkg;
    localparam int HP_W     = 8;
    localparam int DMG1_LSB = 0;
    localparam int DMG2_LSB = 8;

    typedef logic [HP_W-1:0] hp_t;

    typedef enum logic [1:0] {
        FIGHT = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_P1   = 2'b01,
        WIN_P2   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    function automatic hp_t sat_sub(input hp_t a, input hp_t b);
        return (a > b) ? hp_t'(a - b) : '0;
    endfunction
endpackage

// File: rtl/blood_tracker_if.sv
// Bundle between FSM_Control/graphics and the health tracker.
// The master side drives the round controls; the slave side is the tracker itself.
interface blood_tracker_if;
    import kof_pkg::*;

    logic                restart;
    logic                fight_en;
    logic [2*HP_W-1:0]   blood_dec;
    hp_t                 hp1;
    hp_t                 hp2;
    hp_t                 bar1;
    hp_t                 bar2;
    logic                low1;
    logic                low2;
    logic                over;
    logic [1:0]          winner;

    modport master (
        output restart, fight_en, blood_dec,
        input  hp1, hp2, bar1, bar2, low1, low2, over, winner
    );

    modport slave (
        input  restart, fight_en, blood_dec,
        output hp1, hp2, bar1, bar2, low1, low2, over, winner
    );
endinterface

// File: rtl/blood_tracker_hp_channel.sv
// One player's saturating HP register plus the health bar that trails it.
// The bar only moves on a shared drain tick and never goes below the true HP.
module hp_channel
    import kof_pkg::*;
#(
    parameter int HP_MAX = 100,
    parameter int LOW_HP = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic apply,
    input  logic tick,
    input  hp_t  dmg,
    output hp_t  hp,
    output hp_t  bar,
    output logic low,
    output logic zero_next
);
    hp_t hp_next;

    always_comb begin
        hp_next = hp;
        if (apply) hp_next = sat_sub(hp, dmg);
    end

    assign zero_next = apply && (hp_next == '0);
    assign low       = (hp != '0) && (hp <= hp_t'(LOW_HP));

    // Comparing the bar against the current hp keeps bar >= hp_next, since damage only lowers hp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp  <= hp_t'(HP_MAX);
            bar <= hp_t'(HP_MAX);
        end else if (restart) begin
            hp  <= hp_t'(HP_MAX);
            bar <= hp_t'(HP_MAX);
        end else begin
            hp <= hp_next;
            if (tick && (bar > hp)) bar <= bar - 1'b1;
        end
    end
endmodule

// File: rtl/blood_tracker.sv
// Round health tracker: applies damage, drains the health bars and reports KO.
// Owns the bar drain divider, the FIGHT/DRAIN/DONE sequencer, the winner code and the over pulse.
module blood_tracker
    import kof_pkg::*;
#(
    parameter int HP_MAX    = 100,
    parameter int LOW_HP    = 20,
    parameter int DRAIN_DIV = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    blood_tracker_if.slave   bus
);
    localparam int DIV_W = (DRAIN_DIV > 1) ? $clog2(DRAIN_DIV) : 1;

    state_t           state, state_nxt;
    winner_t          winner, winner_nxt;
    logic             over, over_nxt;
    logic [DIV_W-1:0] div;
    logic             tick, apply, zero1, zero2;

    assign tick  = (div == DIV_W'(DRAIN_DIV - 1));
    assign apply = (state == FIGHT) && bus.fight_en && !bus.restart;

    hp_channel #(.HP_MAX(HP_MAX), .LOW_HP(LOW_HP)) u_ch1 (
        .clk(clk), .rst_n(rst_n), .restart(bus.restart), .apply(apply), .tick(tick),
        .dmg(bus.blood_dec[DMG1_LSB +: HP_W]),
        .hp(bus.hp1), .bar(bus.bar1), .low(bus.low1), .zero_next(zero1)
    );

    hp_channel #(.HP_MAX(HP_MAX), .LOW_HP(LOW_HP)) u_ch2 (
        .clk(clk), .rst_n(rst_n), .restart(bus.restart), .apply(apply), .tick(tick),
        .dmg(bus.blood_dec[DMG2_LSB +: HP_W]),
        .hp(bus.hp2), .bar(bus.bar2), .low(bus.low2), .zero_next(zero2)
    );

    always_comb begin
        state_nxt  = state;
        winner_nxt = winner;
        over_nxt   = 1'b0;
        case (state)
            FIGHT: if (zero1 || zero2) begin
                state_nxt  = DRAIN;
                winner_nxt = (zero1 && zero2) ? WIN_DRAW : (zero2 ? WIN_P1 : WIN_P2);
            end
            DRAIN: if ((bus.bar1 == bus.hp1) && (bus.bar2 == bus.hp2)) begin
                state_nxt = DONE;
                over_nxt  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FIGHT;
            winner <= WIN_NONE;
            over   <= 1'b0;
            div    <= '0;
        end else if (bus.restart) begin
            state  <= FIGHT;
            winner <= WIN_NONE;
            over   <= 1'b0;
            div    <= '0;
        end else begin
            state  <= state_nxt;
            winner <= winner_nxt;
            over   <= over_nxt;
            div    <= tick ? '0 : div + 1'b1;
        end
    end

    assign bus.over   = over;
    assign bus.winner = winner;
endmodule

// File: tb/tb_blood_tracker.sv
// Directed bench for blood_tracker with hand-computed expectations (HP_MAX=100, LOW_HP=20, DRAIN_DIV=4).
module tb_blood_tracker;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    blood_tracker_if bus ();

    blood_tracker #(.HP_MAX(100), .LOW_HP(20), .DRAIN_DIV(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hit(input logic [15:0] dmg);
        bus.blood_dec = dmg;
        cyc();
        bus.blood_dec = 16'h0000;
    endtask

    task automatic do_restart();
        bus.restart = 1'b1;
        cyc();
        bus.restart = 1'b0;
    endtask

    task automatic watch_over(input int n, output int pulses, output int b1_at, output int b2_at);
        pulses = 0;
        b1_at  = -1;
        b2_at  = -1;
        for (int i = 0; i < n; i++) begin
            cyc();
            if (bus.over === 1'b1) begin
                pulses++;
                b1_at = int'(bus.bar1);
                b2_at = int'(bus.bar2);
            end
        end
    endtask

    initial begin
        int pulses, b1_at, b2_at, inv_bad;
        logic conv;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        bus.restart   = 1'b0;
        bus.fight_en  = 1'b0;
        bus.blood_dec = 16'h0000;

        // 1: reset values
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        cyc();
        chk("rst_hp1", bus.hp1, 100);
        chk("rst_hp2", bus.hp2, 100);
        chk("rst_bar1", bus.bar1, 100);
        chk("rst_bar2", bus.bar2, 100);
        chk("rst_over", bus.over, 0);
        chk("rst_winner", bus.winner, 0);
        chk("rst_low1", bus.low1, 0);
        chk("rst_low2", bus.low2, 0);

        // 2: basic damage and bar drain
        bus.fight_en = 1'b1;
        hit(16'h0A05);
        chk("dmg_hp1", bus.hp1, 95);
        chk("dmg_hp2", bus.hp2, 90);
        conv    = 1'b0;
        inv_bad = 0;
        for (int i = 0; i < 60 && !conv; i++) begin
            cyc();
            if (bus.bar1 < bus.hp1 || bus.bar2 < bus.hp2) inv_bad++;
            if (bus.bar1 == 8'd95 && bus.bar2 == 8'd90) conv = 1'b1;
        end
        chk("bar_converge", conv, 1);
        chk("bar_invariant", inv_bad, 0);
        chk("bar1_settled", bus.bar1, 95);
        chk("bar2_settled", bus.bar2, 90);

        // 3: saturating KO of player 2, damage ignored afterwards
        hit(16'hFF00);
        chk("ko_hp2_sat", bus.hp2, 0);
        chk("ko_hp1_keep", bus.hp1, 95);
        chk("ko_winner_p1", bus.winner, 1);
        hit(16'h0505);
        chk("drain_hp1_frozen", bus.hp1, 95);
        chk("drain_hp2_frozen", bus.hp2, 0);
        watch_over(500, pulses, b1_at, b2_at);
        chk("ko_over_pulses", pulses, 1);
        chk("ko_over_bar2", b2_at, 0);
        chk("ko_over_bar1", b1_at, 95);
        chk("done_winner_hold", bus.winner, 1);

        // 4: double KO
        do_restart();
        hit(16'h5A5A);
        chk("dbl_hp1_10", bus.hp1, 10);
        chk("dbl_hp2_10", bus.hp2, 10);
        chk("dbl_low1", bus.low1, 1);
        hit(16'h0A0A);
        chk("dbl_hp1_0", bus.hp1, 0);
        chk("dbl_hp2_0", bus.hp2, 0);
        chk("dbl_winner", bus.winner, 3);
        chk("dbl_low1_zero", bus.low1, 0);
        watch_over(600, pulses, b1_at, b2_at);
        chk("dbl_over_pulses", pulses, 1);
        chk("dbl_over_bar1", b1_at, 0);
        chk("dbl_over_bar2", b2_at, 0);

        // 5: restart in the middle of DRAIN
        do_restart();
        hit(16'hFF00);
        chk("r_ko_winner", bus.winner, 1);
        repeat (20) cyc();
        do_restart();
        chk("r_hp1", bus.hp1, 100);
        chk("r_hp2", bus.hp2, 100);
        chk("r_bar1", bus.bar1, 100);
        chk("r_bar2", bus.bar2, 100);
        chk("r_winner", bus.winner, 0);
        bus.fight_en = 1'b0;
        watch_over(450, pulses, b1_at, b2_at);
        chk("r_no_over", pulses, 0);
        bus.fight_en = 1'b1;
        hit(16'h0101);
        chk("r_accept_hp1", bus.hp1, 99);
        chk("r_accept_hp2", bus.hp2, 99);

        // 6: fight_en gating and low-health boundary
        bus.fight_en  = 1'b0;
        bus.blood_dec = 16'h3030;
        repeat (10) cyc();
        bus.blood_dec = 16'h0000;
        chk("gate_hp1", bus.hp1, 99);
        chk("gate_hp2", bus.hp2, 99);
        bus.fight_en = 1'b1;
        hit(16'h004E);
        chk("low_hp1_21", bus.hp1, 21);
        chk("low1_at21", bus.low1, 0);
        hit(16'h0001);
        chk("low_hp1_20", bus.hp1, 20);
        chk("low1_at20", bus.low1, 1);
        chk("low2_at99", bus.low2, 0);
        hit(16'h0014);
        chk("low_hp1_0", bus.hp1, 0);
        chk("low1_at0", bus.low1, 0);
        chk("p2_winner", bus.winner, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
